btn_page_ctrl: RTL and testbench
================================

Name: btn_page_ctrl

Overview:
Parametrised button-driven display/mode controller for the UART board front panel. Synchronises and debounces four push-buttons and turns each debounced press into a single-cycle event. The events drive a page-select state machine: NUM_PAGES pages with wrap-around, plus an independent view toggle. Its outputs select what the LED/seven-segment display logic shows (for example, TX versus RX view and which buffer page).

Parameters:
NUM_PAGES, 4, number of selectable pages; must be at least 2; need not be a power of 2.
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a level change; must be at least 1 (10 ms at 100 MHz).
PW, $clog2(NUM_PAGES), width of page_idx (derived; do not override).

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
BTNU  in  1  raw button, toggles view
BTNR  in  1  raw button, next page
BTNL  in  1  raw button, previous page
BTND  in  1  raw button, home (page 0)
page_idx  out  PW  current page, binary
page_onehot  out  NUM_PAGES  one-hot of page_idx
view_sel  out  1  view flag, toggled by BTNU
btn_evt  out  4  debounced press pulses {D,L,R,U}, one cycle each

Behaviour:
- One clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: page_idx=0, page_onehot=1 (bit 0 set), view_sel=0, btn_evt=0. All synchroniser flops, stable levels and debounce counters are also 0.
- Per button, synchroniser: two-flop synchroniser producing sync.
- Per button, debouncer:
  - Holds a stable level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync equals stable, the counter clears.
  - Otherwise the counter increments.
  - When sync differs from stable and the counter equals DEBOUNCE_CYCLES-1, stable takes sync on that edge and the counter clears.
- Press event: registered; asserted for exactly one cycle, on the same edge where stable goes 0->1. A 1->0 (release) produces no event. A glitch lasting fewer than DEBOUNCE_CYCLES synchronised samples produces nothing and leaves stable unchanged.
- Latency: raw input rises before edge 0 and stays high.
  - s1=1 at edge 0; sync=1 at edge 1.
  - stable=1 and btn_evt bit=1 at edge 1+DEBOUNCE_CYCLES.
  - page_idx/view_sel update at edge 2+DEBOUNCE_CYCLES.
- A held button produces exactly one event. There is no auto-repeat.
- Page FSM: the state is page_idx. It is evaluated on btn_evt each cycle, with priority:
  1. evt_D: page_idx <= 0, regardless of R/L.
  2. evt_R and evt_L together: page unchanged.
  3. evt_R only: page_idx <= (page_idx==NUM_PAGES-1) ? 0 : page_idx+1.
  4. evt_L only: page_idx <= (page_idx==0) ? NUM_PAGES-1 : page_idx-1.
- page_onehot is registered alongside page_idx and is always consistent with it; it is never zero and never multi-hot.
- View: evt_U toggles view_sel. It is independent of page events, so U together with R/L/D applies both actions in the same cycle.
- Wrap arithmetic is explicit compare-and-load; no modulo operators. It must be correct for a non-power-of-2 NUM_PAGES: page_idx never reaches NUM_PAGES.
- Reset mid-operation: all state clears, including partially counted debounces, and no event is emitted during or on exit from reset. A button held through reset release is treated as a new press: one event after 2+DEBOUNCE_CYCLES edges.
- Outputs are driven from flops only; there is no combinational path from any raw input to any output.

Test Plan:
1. Reset, then idle 20 cycles -> page_idx=0, page_onehot=3'b001, view_sel=0, btn_evt=0 throughout.
2. DEBOUNCE_CYCLES=4, NUM_PAGES=3:
   - Stimulus: BTNR rises before edge 0, held 30 cycles, then released.
   - Required: btn_evt[1]=1 only after edge 5; page_idx 0->1 at edge 6; page_onehot=3'b010; no further change on hold or release.
3. DEBOUNCE_CYCLES=4, NUM_PAGES=3, wrap:
   - Stimulus: three clean BTNR presses, then from 0 one BTNL press.
   - Required: page_idx sequence 1,2,0 for the BTNR presses; BTNL from 0 -> 2 (3'b100).
4. Glitch rejection: BTNL pulses high for 3 cycles, repeated 5 times with 3-cycle gaps (DEBOUNCE_CYCLES=4) -> no btn_evt; page_idx unchanged.
5. Simultaneous events:
   - R+L pressed on the same cycle -> page unchanged, btn_evt=4'b0110 for one cycle.
   - D+R at page 2 -> page 0.
   - U+R at page 0 -> page 1 and view_sel toggles 0->1 on the same edge.
6. Reset mid-debounce:
   - BTNU held; reset asserted at edge 3 for 2 cycles, BTNU still held.
   - Required: no event during reset; exactly one btn_evt[0] pulse 2+DEBOUNCE_CYCLES edges after reset deasserts; view_sel=1 on the following edge.

Source files
------------

// File: rtl/btn_page_ctrl.sv
// Front-panel controller: four buttons are synchronised, debounced and turned into press pulses.
// The pulses drive a wrap-around page selector and a view toggle. All outputs are registered.
module btn_page_ctrl #(
    parameter int NUM_PAGES       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PW              = $clog2(NUM_PAGES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 BTNU,
    input  logic                 BTNR,
    input  logic                 BTNL,
    input  logic                 BTND,
    output logic [PW-1:0]        page_idx,
    output logic [NUM_PAGES-1:0] page_onehot,
    output logic                 view_sel,
    output logic [3:0]           btn_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(NUM_PAGES - 1);

    // Bit order everywhere: {D, L, R, U}
    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    sync;
    logic [3:0]    stable;
    logic [CW-1:0] cnt [4];

    logic [PW-1:0]        page_nxt;
    logic [NUM_PAGES-1:0] onehot_nxt;

    assign raw = {BTND, BTNL, BTNR, BTNU};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= '0;
            sync    <= '0;
            stable  <= '0;
            btn_evt <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw;
            sync <= s1;
            for (int i = 0; i < 4; i++) begin
                btn_evt[i] <= 1'b0;
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // Accepted level change; only a rising edge counts as a press.
                    stable[i]  <= sync[i];
                    cnt[i]     <= '0;
                    btn_evt[i] <= sync[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Home wins over everything; next+prev together cancel out.
    always_comb begin
        page_nxt = page_idx;
        if (btn_evt[3]) begin
            page_nxt = '0;
        end else if (btn_evt[1] && !btn_evt[2]) begin
            page_nxt = (page_idx == PAGE_LAST) ? '0 : page_idx + 1'b1;
        end else if (btn_evt[2] && !btn_evt[1]) begin
            page_nxt = (page_idx == '0) ? PAGE_LAST : page_idx - 1'b1;
        end
    end

    always_comb begin
        onehot_nxt = '0;
        for (int k = 0; k < NUM_PAGES; k++) begin
            onehot_nxt[k] = (page_nxt == PW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            page_idx    <= '0;
            page_onehot <= NUM_PAGES'(1);
            view_sel    <= 1'b0;
        end else begin
            page_idx    <= page_nxt;
            page_onehot <= onehot_nxt;
            view_sel    <= view_sel ^ btn_evt[0];
        end
    end

endmodule

// File: tb/tb_btn_page_ctrl.sv
// Bench for btn_page_ctrl: directed front-panel scenarios plus random button activity,
// every cycle compared against a sample-history reference model.
module tb_btn_page_ctrl;

    localparam int NP = 3;
    localparam int DB = 4;
    localparam int PW = $clog2(NP);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          BTNU = 1'b0, BTNR = 1'b0, BTNL = 1'b0, BTND = 1'b0;
    logic [PW-1:0] page_idx;
    logic [NP-1:0] page_onehot;
    logic          view_sel;
    logic [3:0]    btn_evt;

    btn_page_ctrl #(.NUM_PAGES(NP), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset),
        .BTNU(BTNU), .BTNR(BTNR), .BTNL(BTNL), .BTND(BTND),
        .page_idx(page_idx), .page_onehot(page_onehot),
        .view_sel(view_sel), .btn_evt(btn_evt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference state; button bit order {D, L, R, U}
    bit [3:0] m_s1, m_sync, m_stable, m_evt;
    bit       hist [4][$];
    int       m_page;
    bit       m_view;

    int evt_cnt [4];
    int rl_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input bit rst, input bit [3:0] b);
        bit [3:0] nevt;
        bit       all_diff;
        if (rst) begin
            m_s1 = 0; m_sync = 0; m_stable = 0; m_evt = 0;
            m_page = 0; m_view = 0;
            for (int i = 0; i < 4; i++) hist[i].delete();
            return;
        end
        nevt = 0;
        // A level is accepted once the last DB synchronised samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
            hist[i].push_back(m_sync[i]);
            if (hist[i].size() > DB) void'(hist[i].pop_front());
            if (hist[i].size() == DB) begin
                all_diff = 1;
                foreach (hist[i][k]) if (hist[i][k] == m_stable[i]) all_diff = 0;
                if (all_diff) begin
                    m_stable[i] = ~m_stable[i];
                    nevt[i] = m_stable[i];
                    hist[i].delete();
                end
            end
        end
        if (m_evt[3]) m_page = 0;
        else if (m_evt[1] && m_evt[2]) m_page = m_page;
        else if (m_evt[1]) m_page = (m_page + 1) % NP;
        else if (m_evt[2]) m_page = (m_page + NP - 1) % NP;
        m_view = m_view ^ m_evt[0];
        m_evt  = nevt;
        m_sync = m_s1;
        m_s1   = b;
    endtask

    task automatic tick(input bit rst, input bit [3:0] b);
        @(negedge clk);
        reset = rst;
        {BTND, BTNL, BTNR, BTNU} = b;
        @(posedge clk);
        model_edge(rst, b);
        #1;
        check("page_idx", 32'(page_idx), 32'(m_page));
        check("page_onehot", 32'(page_onehot), 32'(1 << m_page));
        check("view_sel", 32'(view_sel), 32'(m_view));
        check("btn_evt", 32'(btn_evt), 32'(m_evt));
        for (int i = 0; i < 4; i++) evt_cnt[i] += int'(btn_evt[i]);
        if (btn_evt == 4'b0110) rl_cnt++;
    endtask

    task automatic press(input bit [3:0] b);
        for (int i = 0; i < 10; i++) tick(0, b);
        for (int i = 0; i < 10; i++) tick(0, 4'b0000);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) evt_cnt[i] = 0;
        rl_cnt = 0;
    endtask

    initial begin
        bit [3:0] rb;
        clear_counts();

        // Reset and idle
        for (int i = 0; i < 3; i++) tick(1, 4'b0000);
        for (int i = 0; i < 20; i++) tick(0, 4'b0000);
        check("idle_page", 32'(page_idx), 32'd0);
        check("idle_onehot", 32'(page_onehot), 32'b001);

        // Single long R press, then release
        clear_counts();
        for (int i = 0; i < 30; i++) tick(0, 4'b0010);
        for (int i = 0; i < 10; i++) tick(0, 4'b0000);
        check("hold_evt_count", 32'(evt_cnt[1]), 32'd1);
        check("hold_page", 32'(page_idx), 32'd1);
        check("hold_onehot", 32'(page_onehot), 32'b010);

        // Wrap forward 1,2,0 then backward from 0 to 2
        tick(1, 4'b0000);
        press(4'b0010); check("wrap_r1", 32'(page_idx), 32'd1);
        press(4'b0010); check("wrap_r2", 32'(page_idx), 32'd2);
        press(4'b0010); check("wrap_r3", 32'(page_idx), 32'd0);
        press(4'b0100); check("wrap_l", 32'(page_idx), 32'd2);
        check("wrap_l_onehot", 32'(page_onehot), 32'b100);

        // Short L glitches are rejected
        clear_counts();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) tick(0, 4'b0100);
            for (int i = 0; i < 3; i++) tick(0, 4'b0000);
        end
        for (int i = 0; i < 10; i++) tick(0, 4'b0000);
        check("glitch_evt", 32'(evt_cnt[2]), 32'd0);
        check("glitch_page", 32'(page_idx), 32'd2);

        // Simultaneous events
        clear_counts();
        press(4'b0110);
        check("rl_pulse", 32'(rl_cnt), 32'd1);
        check("rl_page", 32'(page_idx), 32'd2);
        press(4'b1010);
        check("dr_page", 32'(page_idx), 32'd0);
        press(4'b0011);
        check("ur_page", 32'(page_idx), 32'd1);
        check("ur_view", 32'(view_sel), 32'd1);

        // Reset in the middle of a U debounce, button held throughout
        for (int i = 0; i < 3; i++) tick(0, 4'b0001);
        clear_counts();
        tick(1, 4'b0001);
        tick(1, 4'b0001);
        check("rst_view", 32'(view_sel), 32'd0);
        for (int i = 0; i < 1 + DB; i++) tick(0, 4'b0001);
        check("rst_no_early_evt", 32'(evt_cnt[0]), 32'd0);
        tick(0, 4'b0001);
        check("rst_evt", 32'(btn_evt), 32'b0001);
        tick(0, 4'b0001);
        check("rst_view_set", 32'(view_sel), 32'd1);
        for (int i = 0; i < 10; i++) tick(0, 4'b0001);
        check("rst_single_evt", 32'(evt_cnt[0]), 32'd1);

        // Random button activity with occasional resets
        rb = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            tick($urandom_range(0, 499) == 0, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
